semaforo_cruce: RTL and testbench
=================================

Name: semaforo_cruce

Overview:
Parametrised two-approach intersection traffic-light controller with a latched pedestrian request, a minimum-green guarantee, all-red clearance and a night flashing-amber mode. It generalises the single-approach semaforo: programmable timing, two vehicle channels (A and B), pedestrian phase and mode selection. It sits directly between the board push-button/switch inputs and the lamp drivers.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per timing tick (tick = 1 s on board; small in simulation).
- T_VERDE, 10, green duration in ticks with no pending request, ≥ T_MIN_VERDE.
- T_MIN_VERDE, 3, minimum green in ticks before a pedestrian request may cut it, ≥1.
- T_AMARILLO, 3, amber duration in ticks, ≥1.
- T_ROJO, 1, all-red clearance in ticks, ≥1.
- T_PEATON, 6, pedestrian walk duration in ticks, ≥1.
- CNT_W, 8, width of the phase tick counter; all T_* must be < 2^CNT_W.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- pulsador, input, 1, pedestrian button, synchronous to clk, level may last any number of cycles.
- modo_noche, input, 1, night-mode request level.
- rojo, output, 2, red lamp; bit0 = approach A, bit1 = approach B.
- amarillo, output, 2, amber lamp per approach.
- verde, output, 2, green lamp per approach.
- blanco, output, 1, pedestrian walk lamp.
- pedido, output, 1, pending pedestrian request indicator.

Behaviour:
- Reset: one clock; synchronous, active-high. While rst=1 on a clk edge: state=ROJO_A (all-red before A), prescaler=0, phase counter=0, pedido=0, pulsador edge register=0. Outputs after reset: rojo=2'b11, amarillo=2'b00, verde=2'b00, blanco=0, pedido=0. Reset mid-phase aborts immediately with no amber transition.
- Tick: prescaler counts 0..CLK_DIV-1 and pulses tick when it reaches CLK_DIV-1. The prescaler and phase counter both clear on every state change, so a phase of T ticks lasts exactly T*CLK_DIV cycles.
- Outputs: Moore decode of the registered state. Lamps change in the same cycle the state register updates.
- States and lamps: ROJO_A (all red) → VERDE_A (verde=01, rojo=10) → AMAR_A (amarillo=01, rojo=10) → ROJO_B (all red) → VERDE_B (verde=10, rojo=01) → AMAR_B (amarillo=10, rojo=01) → ROJO_A. PEATON: rojo=11, blanco=1. NOCHE: rojo=00, verde=00, amarillo=11 or 00 alternating, blanco=0.
- Phase end condition: the phase ends on the tick at which the counter reaches T-1, where T is the T_* value of that phase.
- Request latch: a rising edge of pulsador (registered compare) sets pedido. pedido clears on the cycle PEATON is entered. Edges during PEATON are ignored. Edges while pedido=1 have no further effect. A held button produces one request only.
- Green cut: in VERDE_A or VERDE_B with pedido=1, the green ends at the first tick where elapsed ticks ≥ T_MIN_VERDE, instead of at T_VERDE. Amber is never shortened.
- Pedestrian service: at the end of ROJO_A or ROJO_B, if pedido=1, go to PEATON. After T_PEATON ticks, go to the green that would have followed: ROJO_A leads to VERDE_A, ROJO_B leads to VERDE_B. A 1-bit register holds this return target.
- Night entry: modo_noche is sampled only at the end of ROJO_A, ROJO_B or PEATON. It has priority over pedido there and leads to NOCHE. A request in NOCHE stays latched.
- Night operation: amber toggles on every tick, and the first tick after entry shows 11.
- Night exit: on a tick with modo_noche=0, go to ROJO_A. From there pedido is served first if set.
- Simultaneous events: the pulsador edge is latched on the same cycle as a phase end and takes effect at the next decision point. Reset overrides everything.
- Safety invariant: verde and amarillo are never both nonzero on opposite approaches. rojo[i]=0 only when verde[i] or amarillo[i] is set, or in NOCHE.

Decomposition:
- Package semaforo_pkg: state enum typedef (ROJO_A, VERDE_A, AMAR_A, ROJO_B, VERDE_B, AMAR_B, PEATON, NOCHE), lamp index constants (APR_A=0, APR_B=1).
- Sub-module semaforo_prescaler (CLK_DIV; ports clk, rst, clr, tick).
- FSM, counter, request latch and output decode stay in semaforo_cruce.

Test Plan:
All scenarios use CLK_DIV=2, T_VERDE=5, T_MIN_VERDE=2, T_AMARILLO=2, T_ROJO=1, T_PEATON=3.
- Reset then idle → rojo=11 for 2 cycles, then VERDE_A for 10 cycles, AMAR_A 4, ROJO_B 2, VERDE_B 10, AMAR_B 4; the cycle repeats with period 32 cycles.
- 1-cycle pulsador pulse 2 cycles into VERDE_A → pedido=1; green ends after 4 cycles total; AMAR_A 4, ROJO_B 2, PEATON (blanco=1, rojo=11) 6 cycles, pedido=0 on PEATON entry, then VERDE_B.
- pulsador held 40 cycles → exactly one PEATON phase is served; a second press after PEATON ends produces a second PEATON.
- modo_noche=1 asserted during VERDE_A → green/amber complete normally; at end of ROJO_B enter NOCHE; amarillo alternates 11/00 every 2 cycles; deassert → ROJO_A then VERDE_A.
- modo_noche=1 and pedido=1 at end of ROJO_A → NOCHE is entered and pedido stays 1; after exit, PEATON follows ROJO_A.
- rst=1 asserted for one cycle mid-AMAR_B → next cycle shows rojo=11, pedido=0, and timing restarts from ROJO_A.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types for the two-approach intersection controller: FSM states,
// lamp indices and the Moore lamp decode used by semaforo_cruce.
package semaforo_pkg;

    typedef enum logic [2:0] {
        ROJO_A,
        VERDE_A,
        AMAR_A,
        ROJO_B,
        VERDE_B,
        AMAR_B,
        PEATON,
        NOCHE
    } estado_t;

    localparam int unsigned APR_A = 0;
    localparam int unsigned APR_B = 1;

    typedef struct packed {
        logic [1:0] rojo;
        logic [1:0] amarillo;
        logic [1:0] verde;
        logic       blanco;
    } lamparas_t;

    function automatic lamparas_t decodificar(input estado_t est, input logic parpadeo);
        lamparas_t l;
        l.rojo     = 2'b11;
        l.amarillo = 2'b00;
        l.verde    = 2'b00;
        l.blanco   = 1'b0;
        case (est)
            VERDE_A: begin
                l.verde[APR_A] = 1'b1;
                l.rojo[APR_A]  = 1'b0;
            end
            AMAR_A: begin
                l.amarillo[APR_A] = 1'b1;
                l.rojo[APR_A]     = 1'b0;
            end
            VERDE_B: begin
                l.verde[APR_B] = 1'b1;
                l.rojo[APR_B]  = 1'b0;
            end
            AMAR_B: begin
                l.amarillo[APR_B] = 1'b1;
                l.rojo[APR_B]     = 1'b0;
            end
            PEATON: l.blanco = 1'b1;
            NOCHE: begin
                l.rojo     = 2'b00;
                l.amarillo = {2{parpadeo}};
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_prescaler.sv
// Timing prescaler: free-running 0..CLK_DIV-1 counter that pulses tick on its
// last count and restarts whenever the controller changes phase.
module semaforo_prescaler #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] L_FIN = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == L_FIN);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/semaforo_cruce.sv
// Two-approach traffic-light controller with latched pedestrian request,
// minimum-green cut, all-red clearance and night flashing-amber mode.
module semaforo_cruce
    import semaforo_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 50_000_000,
    parameter int unsigned T_VERDE     = 10,
    parameter int unsigned T_MIN_VERDE = 3,
    parameter int unsigned T_AMARILLO  = 3,
    parameter int unsigned T_ROJO      = 1,
    parameter int unsigned T_PEATON    = 6,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulsador,
    input  logic       modo_noche,
    output logic [1:0] rojo,
    output logic [1:0] amarillo,
    output logic [1:0] verde,
    output logic       blanco,
    output logic       pedido
);

    localparam logic [CNT_W-1:0] L_VERDE = CNT_W'(T_VERDE - 1);
    localparam logic [CNT_W-1:0] L_MIN   = CNT_W'(T_MIN_VERDE - 1);
    localparam logic [CNT_W-1:0] L_AMAR  = CNT_W'(T_AMARILLO - 1);
    localparam logic [CNT_W-1:0] L_ROJO  = CNT_W'(T_ROJO - 1);
    localparam logic [CNT_W-1:0] L_PEAT  = CNT_W'(T_PEATON - 1);

    estado_t          r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pedido;
    logic             r_puls;
    logic             r_ret;     // 0: PEATON returns to VERDE_A, 1: to VERDE_B
    logic             r_parpadeo;
    lamparas_t        r_luces;

    estado_t w_estado_d;
    logic    w_ret_d;
    logic    w_parpadeo_d;
    logic    w_tick;
    logic    w_fin;
    logic    w_cambio;
    logic    w_flanco;

    assign w_cambio = (w_estado_d != r_estado);
    assign w_flanco = pulsador & ~r_puls;

    semaforo_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (w_cambio),
        .tick(w_tick)
    );

    always_comb begin
        w_fin = 1'b0;
        unique case (r_estado)
            VERDE_A, VERDE_B:
                w_fin = w_tick && ((r_cnt == L_VERDE) || (r_pedido && (r_cnt >= L_MIN)));
            AMAR_A, AMAR_B: w_fin = w_tick && (r_cnt == L_AMAR);
            ROJO_A, ROJO_B: w_fin = w_tick && (r_cnt == L_ROJO);
            PEATON:         w_fin = w_tick && (r_cnt == L_PEAT);
            NOCHE:          w_fin = w_tick && !modo_noche;
            default:        w_fin = 1'b0;
        endcase
    end

    // Night mode outranks a pending request at every all-red decision point.
    always_comb begin
        w_estado_d = r_estado;
        w_ret_d    = r_ret;
        if (w_fin) begin
            unique case (r_estado)
                ROJO_A: begin
                    if (modo_noche) begin
                        w_estado_d = NOCHE;
                    end else if (r_pedido) begin
                        w_estado_d = PEATON;
                        w_ret_d    = 1'b0;
                    end else begin
                        w_estado_d = VERDE_A;
                    end
                end
                VERDE_A: w_estado_d = AMAR_A;
                AMAR_A:  w_estado_d = ROJO_B;
                ROJO_B: begin
                    if (modo_noche) begin
                        w_estado_d = NOCHE;
                    end else if (r_pedido) begin
                        w_estado_d = PEATON;
                        w_ret_d    = 1'b1;
                    end else begin
                        w_estado_d = VERDE_B;
                    end
                end
                VERDE_B: w_estado_d = AMAR_B;
                AMAR_B:  w_estado_d = ROJO_A;
                PEATON:  w_estado_d = modo_noche ? NOCHE : (r_ret ? VERDE_B : VERDE_A);
                NOCHE:   w_estado_d = ROJO_A;
                default: w_estado_d = ROJO_A;
            endcase
        end
    end

    always_comb begin
        w_parpadeo_d = r_parpadeo;
        if (w_estado_d == NOCHE && r_estado != NOCHE) begin
            w_parpadeo_d = 1'b1;
        end else if (r_estado == NOCHE && w_tick) begin
            w_parpadeo_d = ~r_parpadeo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado   <= ROJO_A;
            r_cnt      <= '0;
            r_pedido   <= 1'b0;
            r_puls     <= 1'b0;
            r_ret      <= 1'b0;
            r_parpadeo <= 1'b0;
            r_luces    <= decodificar(ROJO_A, 1'b0);
        end else begin
            r_estado   <= w_estado_d;
            r_ret      <= w_ret_d;
            r_parpadeo <= w_parpadeo_d;
            r_puls     <= pulsador;
            r_luces    <= decodificar(w_estado_d, w_parpadeo_d);
            if (w_cambio) begin
                r_cnt <= '0;
            end else if (w_tick && r_estado != NOCHE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_estado_d == PEATON && r_estado != PEATON) begin
                r_pedido <= 1'b0;
            end else if (w_flanco && r_estado != PEATON) begin
                r_pedido <= 1'b1;
            end
        end
    end

    assign rojo     = r_luces.rojo;
    assign amarillo = r_luces.amarillo;
    assign verde    = r_luces.verde;
    assign blanco   = r_luces.blanco;
    assign pedido   = r_pedido;

endmodule

// File: tb/tb_semaforo_cruce.sv
// Directed bench for semaforo_cruce: expected lamp/request snapshots are queued
// per cycle and compared against the DUT on the falling clock edge.
module tb_semaforo_cruce;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulsador;
    logic       modo_noche;
    logic [1:0] rojo;
    logic [1:0] amarillo;
    logic [1:0] verde;
    logic       blanco;
    logic       pedido;

    // {rojo, amarillo, verde, blanco}
    localparam logic [6:0] L_RA   = 7'b11_00_00_0;
    localparam logic [6:0] L_VA   = 7'b10_00_01_0;
    localparam logic [6:0] L_AA   = 7'b10_01_00_0;
    localparam logic [6:0] L_VB   = 7'b01_00_10_0;
    localparam logic [6:0] L_AB   = 7'b01_10_00_0;
    localparam logic [6:0] L_PE   = 7'b11_00_00_1;
    localparam logic [6:0] L_NON  = 7'b00_11_00_0;
    localparam logic [6:0] L_NOFF = 7'b00_00_00_0;

    logic [7:0] sb[$];
    int         n_eval = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    semaforo_cruce #(
        .CLK_DIV    (2),
        .T_VERDE    (5),
        .T_MIN_VERDE(2),
        .T_AMARILLO (2),
        .T_ROJO     (1),
        .T_PEATON   (3),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulsador  (pulsador),
        .modo_noche(modo_noche),
        .rojo      (rojo),
        .amarillo  (amarillo),
        .verde     (verde),
        .blanco    (blanco),
        .pedido    (pedido)
    );

    task automatic fase(input string tag, input logic [6:0] luz, input logic ped, input int n);
        logic [7:0] obs;
        logic [7:0] esp;
        for (int i = 0; i < n; i++) begin
            sb.push_back({luz, ped});
            obs = {rojo, amarillo, verde, blanco, pedido};
            esp = sb.pop_front();
            n_eval++;
            assert (obs === esp) else begin
                n_fail++;
                $error("FAIL %s[%0d] rojo_amar_verde_blanco_pedido observado=%b esperado=%b",
                       tag, i, obs, esp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pulsador   = 1'b0;
        modo_noche = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle cycle, period 32
        fase("reset_RA", L_RA, 1'b0, 2);
        fase("idle_VA", L_VA, 1'b0, 10);
        fase("idle_AA", L_AA, 1'b0, 4);
        fase("idle_RB", L_RA, 1'b0, 2);
        fase("idle_VB", L_VB, 1'b0, 10);
        fase("idle_AB", L_AB, 1'b0, 4);
        fase("idle_RA", L_RA, 1'b0, 2);

        // Short press in VERDE_A cuts green, PEATON after ROJO_B
        fase("pulso_VA", L_VA, 1'b0, 2);
        pulsador = 1'b1;
        fase("pulso_VA", L_VA, 1'b0, 1);
        pulsador = 1'b0;
        fase("corte_VA", L_VA, 1'b1, 1);
        fase("pulso_AA", L_AA, 1'b1, 4);
        fase("pulso_RB", L_RA, 1'b1, 2);
        fase("pulso_PE", L_PE, 1'b0, 6);
        fase("pulso_VB", L_VB, 1'b0, 10);
        fase("pulso_AB", L_AB, 1'b0, 4);

        // Held button for 40 cycles yields exactly one PEATON
        pulsador = 1'b1;
        fase("largo_RA", L_RA, 1'b0, 1);
        fase("largo_RA", L_RA, 1'b1, 1);
        fase("largo_PE", L_PE, 1'b0, 6);
        fase("largo_VA", L_VA, 1'b0, 10);
        fase("largo_AA", L_AA, 1'b0, 4);
        fase("largo_RB", L_RA, 1'b0, 2);
        fase("largo_VB", L_VB, 1'b0, 10);
        fase("largo_AB", L_AB, 1'b0, 4);
        fase("largo_RA2", L_RA, 1'b0, 2);
        pulsador = 1'b0;
        fase("seg_VA", L_VA, 1'b0, 2);
        pulsador = 1'b1;
        fase("seg_VA", L_VA, 1'b0, 1);
        pulsador = 1'b0;
        fase("seg_corte", L_VA, 1'b1, 1);
        fase("seg_AA", L_AA, 1'b1, 4);
        fase("seg_RB", L_RA, 1'b1, 2);
        fase("seg_PE", L_PE, 1'b0, 6);
        fase("seg_VB", L_VB, 1'b0, 10);
        fase("seg_AB", L_AB, 1'b0, 4);

        // Night request during VERDE_A, entered at end of ROJO_B
        fase("noche_RA", L_RA, 1'b0, 2);
        modo_noche = 1'b1;
        fase("noche_VA", L_VA, 1'b0, 10);
        fase("noche_AA", L_AA, 1'b0, 4);
        fase("noche_RB", L_RA, 1'b0, 2);
        fase("noche_on", L_NON, 1'b0, 2);
        fase("noche_off", L_NOFF, 1'b0, 2);
        fase("noche_on", L_NON, 1'b0, 2);
        fase("noche_off", L_NOFF, 1'b0, 2);
        modo_noche = 1'b0;
        fase("noche_ult", L_NON, 1'b0, 2);
        fase("sal_RA", L_RA, 1'b0, 2);
        fase("sal_VA", L_VA, 1'b0, 10);
        fase("sal_AA", L_AA, 1'b0, 4);
        fase("sal_RB", L_RA, 1'b0, 2);
        fase("sal_VB", L_VB, 1'b0, 10);
        fase("sal_AB", L_AB, 1'b0, 4);

        // Night wins over pending request; request survives and is served after exit
        pulsador   = 1'b1;
        modo_noche = 1'b1;
        fase("np_RA", L_RA, 1'b0, 1);
        pulsador = 1'b0;
        fase("np_RA", L_RA, 1'b1, 1);
        fase("np_on", L_NON, 1'b1, 2);
        fase("np_off", L_NOFF, 1'b1, 2);
        modo_noche = 1'b0;
        fase("np_ult", L_NON, 1'b1, 2);
        fase("np_RA2", L_RA, 1'b1, 2);
        fase("np_PE", L_PE, 1'b0, 6);
        fase("np_VA", L_VA, 1'b0, 10);
        fase("np_AA", L_AA, 1'b0, 4);
        fase("np_RB", L_RA, 1'b0, 2);
        fase("np_VB", L_VB, 1'b0, 10);
        fase("np_AB", L_AB, 1'b0, 4);

        // Reset mid-AMAR_B with a pending request
        fase("rst_RA", L_RA, 1'b0, 2);
        fase("rst_VA", L_VA, 1'b0, 10);
        fase("rst_AA", L_AA, 1'b0, 4);
        fase("rst_RB", L_RA, 1'b0, 2);
        pulsador = 1'b1;
        fase("rst_VB", L_VB, 1'b0, 1);
        pulsador = 1'b0;
        fase("rst_VBcorte", L_VB, 1'b1, 3);
        fase("rst_AB", L_AB, 1'b1, 2);
        rst = 1'b1;
        fase("rst_AB", L_AB, 1'b1, 1);
        rst = 1'b0;
        fase("tras_rst_RA", L_RA, 1'b0, 2);
        fase("tras_rst_VA", L_VA, 1'b0, 10);
        fase("tras_rst_AA", L_AA, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
